// File: rtl/master_read_interface.sv
// AXI-Lite read master: turns one user read request into an AR/R transaction,
// with a cycle-budget timeout that returns an error response instead of hanging.
module master_read_interface #(
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 REQ_VALID,
    input  logic [REG_WIDTH-1:0] REQ_ADDR,
    output logic                 REQ_READY,
    output logic                 RSP_VALID,
    output logic [REG_WIDTH-1:0] RSP_DATA,
    output logic                 RSP_ERR,
    input  logic                 RSP_READY,
    output logic [REG_WIDTH-1:0] ARADDR,
    output logic                 ARVALID,
    input  logic                 ARREADY,
    input  logic [REG_WIDTH-1:0] RDATA,
    input  logic                 RVALID,
    output logic                 RREADY
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYCLES);

    logic [1:0]           state_q, state_d;
    logic [REG_WIDTH-1:0] araddr_q, araddr_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [REG_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 addr_done_q, addr_done_d;
    logic                 data_done_q, data_done_d;
    logic [15:0]          cnt_q, cnt_d;

    logic ar_hs, r_hs;

    assign ar_hs = arvalid_q & ARREADY;
    assign r_hs  = rready_q & RVALID;

    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        addr_done_d = addr_done_q;
        data_done_d = data_done_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    araddr_d    = REQ_ADDR;
                    arvalid_d   = 1'b1;
                    rready_d    = 1'b1;
                    addr_done_d = 1'b0;
                    data_done_d = 1'b0;
                    cnt_d       = 16'd0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                cnt_d       = cnt_q + 16'd1;
                addr_done_d = addr_done_q | ar_hs;
                data_done_d = data_done_q | r_hs;
                if (ar_hs) arvalid_d = 1'b0;
                if (r_hs) begin
                    rsp_data_d = RDATA;
                    rready_d   = 1'b0;
                end
                // Completion is checked first so it wins a tie with the timeout.
                if (addr_done_d && data_done_d) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (cnt_d == TimeoutCnt) begin
                    arvalid_d   = 1'b0;
                    rready_d    = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            addr_done_q <= 1'b0;
            data_done_q <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            addr_done_q <= addr_done_d;
            data_done_q <= data_done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign REQ_READY = (state_q == IDLE);
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign ARADDR    = araddr_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;

endmodule
